jt10_adpcmb_interp: RTL and testbench

- Linear interpolator downstream of the ADPCM-B decoder, producing a smooth PCM stream at the output sample rate.
- On each new decoded sample it measures the sample period in output ticks.
- It computes slope = (new − old) / period with an instantiated serial divider, then ramps the output by that slope on every output tick, clamping at the target.
- Sits between the ADPCM-B decoder and the channel mixer.

---
 rtl/jt10_adpcmb_interp_pkg.sv | 16 +
 rtl/jt10_adpcm_div.sv | 62 ++++++
 rtl/jt10_adpcmb_interp.sv | 140 ++++++++++++++
 tb/tb_jt10_adpcmb_interp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt10_adpcmb_interp_pkg.sv
// Shared constants and FSM encoding for the ADPCM-B output interpolator.
// Defaults give Q.7 slopes and a divider wide enough for a full-scale delta.
package jt10_adpcmb_interp_pkg;

  localparam int FRAC_DEF = 7;
  localparam int DIVW_DEF = 24;
  localparam int CW_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/jt10_adpcm_div.sv
// Restoring serial divider: one quotient bit per cen, DIVW cens per division.
// A start strobe while working abandons the current division and reloads.
module jt10_adpcm_div
  import jt10_adpcmb_interp_pkg::*;
#(
  parameter int DIVW = DIVW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            start,
  input  logic [DIVW-1:0] a,
  input  logic [DIVW-1:0] b,
  output logic [DIVW-1:0] d,
  output logic            working
);

  localparam int NW = $clog2(DIVW + 1);

  logic [DIVW-1:0] b_r;
  logic [DIVW:0]   rem;
  logic [DIVW:0]   rem_shift;
  logic [DIVW:0]   diff;
  logic [NW-1:0]   left;

  // The dividend shifts out of d while quotient bits shift in from the bottom.
  always_comb begin
    rem_shift = {rem[DIVW-1:0], d[DIVW-1]};
    diff      = rem_shift - {1'b0, b_r};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d       <= '0;
      b_r     <= '0;
      rem     <= '0;
      left    <= '0;
      working <= 1'b0;
    end else if (cen) begin
      if (start) begin
        d       <= a;
        b_r     <= b;
        rem     <= '0;
        left    <= NW'(DIVW);
        working <= 1'b1;
      end else if (working) begin
        if (!diff[DIVW]) begin
          rem <= diff;
          d   <= {d[DIVW-2:0], 1'b1};
        end else begin
          rem <= rem_shift;
          d   <= {d[DIVW-2:0], 1'b0};
        end
        left    <= left - 1'b1;
        working <= (left != NW'(1));
      end
    end
  end

endmodule

// File: rtl/jt10_adpcmb_interp.sv
// Linear interpolator between the ADPCM-B decoder and the mixer: measures the
// input sample period in output ticks and ramps toward each new sample.
module jt10_adpcmb_interp
  import jt10_adpcmb_interp_pkg::*;
#(
  parameter int FRAC = FRAC_DEF,
  parameter int DIVW = DIVW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        cen_out,
  input  logic        adv,
  input  logic [15:0] pcmdec,
  output logic [15:0] pcmout,
  output logic        busy
);

  localparam int AW = 16 + FRAC + 2;

  state_t state, state_nx;

  logic signed [AW-1:0] acc, step, step_mag, target, sum;
  logic signed [15:0]   x0, x1;
  logic signed [16:0]   delta;
  logic [16:0]          mag;
  logic [CW-1:0]        cnt, period;
  logic [DIVW-1:0]      num, den, quot;
  logic                 div_start, div_working, delta_neg, wait_first, tick;
  logic                 step_ready;

  assign tick = cen & cen_out;

  // Period in output ticks; an adv sharing a cycle with a tick counts that tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= CW'(1);
    end else if (cen && adv) begin
      period <= (cnt == '0) ? CW'(1) : cnt;
      cnt    <= tick ? CW'(1) : '0;
    end else if (tick && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    delta    = {x1[15], x1} - {x0[15], x0};
    mag      = delta[16] ? $unsigned(-delta) : $unsigned(delta);
    num      = {{(DIVW-17){1'b0}}, mag} << FRAC;
    den      = {{(DIVW-CW){1'b0}}, period};
    target   = {{2{x1[15]}}, x1, {FRAC{1'b0}}};
    sum      = acc + step;
    step_mag = AW'(quot);
  end

  // The divider's working flag is trusted only from the second cen after start.
  assign step_ready = !wait_first && !div_working;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    div_start = (state == LOAD);
    busy      = (state == WAIT);
    if (cen) begin
      if (adv) begin
        state_nx = LOAD;
      end else begin
        case (state)
          LOAD:    state_nx = WAIT;
          WAIT:    if (step_ready) state_nx = RUN;
          default: ;
        endcase
      end
    end
  end

  // A new sample always snaps to the previous target, so a ramp never carries
  // a stale slope across samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      x0         <= '0;
      x1         <= '0;
      step       <= '0;
      delta_neg  <= 1'b0;
      wait_first <= 1'b0;
    end else if (cen) begin
      if (adv) begin
        acc <= target;
        x0  <= x1;
        x1  <= $signed(pcmdec);
      end else begin
        case (state)
          LOAD: begin
            delta_neg  <= delta[16];
            wait_first <= 1'b1;
          end
          WAIT: begin
            wait_first <= 1'b0;
            if (step_ready) step <= delta_neg ? -step_mag : step_mag;
          end
          RUN: begin
            if (cen_out && step != '0) begin
              if ((!step[AW-1] && sum > target) || (step[AW-1] && sum < target))
                acc <= target;
              else
                acc <= sum;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcmout <= '0;
    else        pcmout <= acc[FRAC+15:FRAC];
  end

  jt10_adpcm_div #(.DIVW(DIVW)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .start   (div_start),
    .a       (num),
    .b       (den),
    .d       (quot),
    .working (div_working)
  );

endmodule

// File: tb/tb_jt10_adpcmb_interp.sv
// Self-checking bench for jt10_adpcmb_interp: directed scenarios plus random
// sample streams checked against an event-level interpolation model.
module tb_jt10_adpcmb_interp;

  localparam int FRAC      = 7;
  localparam int DIVW      = 24;
  localparam int READY_CEN = DIVW + 3;
  localparam int CNT_MAX   = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic        cen_out;
  logic        adv;
  logic [15:0] pcmdec;
  logic [15:0] pcmout;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int     m_x0, m_x1, m_cnt, m_period, m_cens;
  longint m_acc, m_step;

  jt10_adpcmb_interp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .cen_out (cen_out),
    .adv     (adv),
    .pcmdec  (pcmdec),
    .pcmout  (pcmout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_x0 = 0; m_x1 = 0; m_cnt = 0; m_period = 1; m_cens = 0;
    m_acc = 0; m_step = 0;
  endfunction

  // Effect of one cen edge: new samples snap and re-slope, ticks ramp only once
  // the slope for the current pair has had time to be computed.
  function automatic void model_edge(input bit a, input bit t, input int s);
    longint delta, mag, nxt, tgt;
    m_cens++;
    if (a) begin
      m_period = (m_cnt < 1) ? 1 : m_cnt;
      m_cnt    = t ? 1 : 0;
      m_acc    = longint'(m_x1) * (1 << FRAC);
      m_x0     = m_x1;
      m_x1     = s;
      delta    = longint'(m_x1) - longint'(m_x0);
      mag      = ((delta < 0 ? -delta : delta) * (1 << FRAC)) / m_period;
      m_step   = (delta < 0) ? -mag : mag;
      m_cens   = 0;
    end else if (t) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_cens >= READY_CEN && m_step != 0) begin
        nxt = m_acc + m_step;
        tgt = longint'(m_x1) * (1 << FRAC);
        if (m_step > 0 && nxt > tgt) nxt = tgt;
        if (m_step < 0 && nxt < tgt) nxt = tgt;
        m_acc = nxt;
      end
    end
  endfunction

  function automatic longint exp_pcm();
    return m_acc >>> FRAC;
  endfunction

  task automatic drive(input bit a, input bit t, input int s, input bit c);
    @(negedge clk);
    adv     = a;
    cen_out = t;
    cen     = c | a | t;
    pcmdec  = 16'(s);
    if (cen) model_edge(a, t, s);
  endtask

  task automatic idle_rand();
    drive(1'b0, 1'b0, 0, $urandom_range(0, 3) != 0);
  endtask

  task automatic settle();
    for (int i = 0; i < 200 && m_cens < READY_CEN + 5; i++) idle_rand();
    check("busy_idle", busy, 0);
  endtask

  // Sample strobe, then two full-rate cycles: divider running, acc snapped.
  task automatic send_chk(input int s, input bit t, input string tag);
    drive(1'b1, t, s, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b1);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_snap"}, $signed(pcmout), exp_pcm());
  endtask

  task automatic tick_only();
    drive(1'b0, 1'b1, 0, 1'b1);
    idle_rand();
    idle_rand();
  endtask

  task automatic tick_chk(input string tag);
    tick_only();
    check(tag, $signed(pcmout), exp_pcm());
  endtask

  task automatic tick_exp(input string tag, input int exp);
    tick_only();
    check(tag, $signed(pcmout), exp);
  endtask

  function automatic int rand_sample();
    case ($urandom_range(0, 3))
      0:       return ($urandom_range(0, 1) != 0) ? -32768 : 32767;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    int ramp_up[8]   = '{100, 200, 300, 400, 400, 400, 400, 400};
    int ramp_dn[9]   = '{300, 200, 100, 0, -100, -200, -300, -400, -400};
    int ramp_sm[4]   = '{3, 6, 9, 10};
    int s, s2, r;

    rst_n = 1'b0; cen = 1'b0; cen_out = 1'b0; adv = 1'b0; pcmdec = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pcmout", $signed(pcmout), 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // 0 then 400 over 4 ticks, then 400 -> -400 over 8 ticks
    send_chk(0, 1'b0, "s0");
    settle();
    for (int i = 0; i < 4; i++) tick_exp("flat0", 0);
    send_chk(400, 1'b0, "s400");
    settle();
    foreach (ramp_up[i]) tick_exp("ramp_up", ramp_up[i]);
    send_chk(-400, 1'b0, "sm400");
    check("snap_400", $signed(pcmout), 400);
    settle();
    foreach (ramp_dn[i]) tick_exp("ramp_dn", ramp_dn[i]);

    // 0 then 10 over 3 ticks: step 426, clamp on the fourth tick
    send_chk(0, 1'b0, "s0b");
    settle();
    for (int i = 0; i < 3; i++) tick_chk("partial");
    send_chk(10, 1'b0, "s10");
    settle();
    foreach (ramp_sm[i]) tick_exp("ramp_clamp", ramp_sm[i]);

    // Full-scale swing in a single tick
    send_chk(32767, 1'b0, "smax");
    settle();
    tick_chk("to_max");
    send_chk(-32768, 1'b0, "smin");
    check("snap_max", $signed(pcmout), 32767);
    settle();
    tick_exp("full_swing", -32768);
    tick_exp("full_hold", -32768);

    // Two samples with no tick between them -> period 1
    send_chk(5, 1'b0, "s5");
    settle();
    send_chk(1285, 1'b0, "s1285");
    settle();
    tick_exp("period_one", 1285);

    // Sample arriving mid-division: old slope discarded
    drive(1'b1, 1'b0, 2000, 1'b1);
    repeat (10) drive(1'b0, 1'b0, 0, 1'b1);
    check("abort_busy", busy, 1);
    send_chk(3000, 1'b0, "abort");
    check("abort_snap", $signed(pcmout), 2000);
    settle();
    tick_exp("abort_new", 3000);

    // Tick during the division holds the output but still counts
    send_chk(3100, 1'b0, "s3100");
    tick_exp("held_tick", 3000);
    settle();
    tick_exp("after_held", 3100);
    send_chk(3300, 1'b0, "s3300");
    settle();
    tick_exp("period_two_a", 3200);
    tick_exp("period_two_b", 3300);

    // Asynchronous reset in the middle of a division
    send_chk(-1000, 1'b0, "sm1000");
    settle();
    tick_chk("pre_reset");
    drive(1'b1, 1'b0, 500, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pcmout", $signed(pcmout), 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_chk(100, 1'b0, "post_rst");
    check("post_rst_zero", $signed(pcmout), 0);
    settle();
    tick_exp("post_rst_ramp", 100);

    // Random sample streams
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      s = rand_sample();
      if (r < 2) begin
        drive(1'b1, 1'b0, s, 1'b1);
        repeat ($urandom_range(2, 15)) drive(1'b0, 1'b0, 0, 1'b1);
        s2 = rand_sample();
        send_chk(s2, $urandom_range(0, 1) != 0, "rnd_abort");
      end else begin
        send_chk(s, r == 2, "rnd");
        if (r == 3) tick_chk("rnd_held");
      end
      settle();
      repeat ($urandom_range(0, 6)) tick_chk("rnd_tick");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
